intersection_scheduler: RTL and testbench

- Four-approach intersection phase scheduler; sequences one green approach at a time with round-robin arbitration across vehicle-sensor requests.
- Inserts yellow and all-red clearance intervals between approaches, plus a pedestrian walk phase on button demand.
- Drives four one-hot lamp groups using the same Red/Yellow/Green encoding as the two-way signal block.
- Sits between the sensor/button front end and the lamp drivers.

---
 rtl/intersection_scheduler.sv | 177 +++++++++++++++++
 tb/tb_intersection_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Purpose: four-approach traffic phase scheduler, round-robin green, yellow/all-red clearance, pedestrian walk.
// Latency: all outputs registered; a decision taken on a clk edge is visible on the lamps right after that edge.
// Backpressure: none; req is a level and ped_bt a latched press, so demand waits in place until its decision point.
// Ports: clk/rst (async active-low) | req[3:0] vehicle demand | ped_bt async button
//        light[11:0] R/Y/G one-hot per approach (bits 3i+2:3i) | walk | grant served index | phase current state
module intersection_scheduler #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 12,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic        ped_bt,
  output logic [11:0] light,
  output logic        walk,
  output logic [1:0]  grant,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    ST_ALL_RED  = 2'd0,
    ST_GREEN    = 2'd1,
    ST_YELLOW   = 2'd2,
    ST_PED_WALK = 2'd3
  } state_t;

  // Green counts far enough to evaluate both the min and max thresholds.
  localparam int G_SAT_I = (T_GREEN_MAX > T_GREEN_MIN) ? T_GREEN_MAX : T_GREEN_MIN;

  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] G_SAT     = CNT_W'(G_SAT_I - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(T_WALK - 1);

  localparam logic [2:0]  LAMP_R    = 3'b001;
  localparam logic [2:0]  LAMP_Y    = 3'b010;
  localparam logic [2:0]  LAMP_G    = 3'b100;
  localparam logic [11:0] LIGHT_RST = 12'b001001001001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_lim;
  logic [1:0]       grant_q, grant_d;
  logic [11:0]      light_q, light_d;
  logic             walk_q, walk_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_last_q, ped_last_d;
  logic [2:0]       sync_q, sync_d;   // [0],[1] synchroniser, [2] edge-detect history

  logic       any_req;
  logic       competing;
  logic       ped_edge;
  logic       ped_clr;
  logic       found;
  logic [1:0] cand;
  logic [1:0] next_grant;

  assign any_req   = |req;
  assign ped_edge  = sync_q[1] & ~sync_q[2];
  assign competing = (|(req & ~(4'b0001 << grant_q))) | ped_pend_q;

  // Round-robin search: grant+1, grant+2, grant+3, then grant itself.
  always_comb begin
    next_grant = grant_q;
    found      = 1'b0;
    cand       = grant_q;
    for (int k = 1; k <= 4; k++) begin
      cand = grant_q + 2'(k);
      if (!found && req[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ped_last_d = ped_last_q;
    ped_clr    = 1'b0;
    sync_d     = {sync_q[1:0], ped_bt};

    case (state_q)
      ST_ALL_RED: begin
        if (cnt_q >= AR_LAST) begin
          // ped_last yields to waiting vehicles so walks never run back to back.
          if (ped_pend_q && !(ped_last_q && any_req)) begin
            state_d    = ST_PED_WALK;
            ped_clr    = 1'b1;
            ped_last_d = 1'b1;
          end else if (any_req) begin
            state_d    = ST_GREEN;
            grant_d    = next_grant;
            ped_last_d = 1'b0;
          end
        end
      end
      ST_GREEN: begin
        if ((cnt_q >= GMIN_LAST && !req[grant_q]) ||
            (cnt_q >= GMAX_LAST && competing)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (cnt_q >= Y_LAST) state_d = ST_ALL_RED;
      end
      ST_PED_WALK: begin
        if (cnt_q >= W_LAST) state_d = ST_ALL_RED;
      end
      default: state_d = ST_ALL_RED;
    endcase

    case (state_q)
      ST_ALL_RED: cnt_lim = AR_LAST;
      ST_GREEN:   cnt_lim = G_SAT;
      ST_YELLOW:  cnt_lim = Y_LAST;
      default:    cnt_lim = W_LAST;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q < cnt_lim) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // A new press wins over the clear on walk entry.
    ped_pend_d = ped_edge | (ped_pend_q & ~ped_clr);

    // Lamps are decoded from the next state so they leave the flop with it.
    walk_d = (state_d == ST_PED_WALK);
    for (int i = 0; i < 4; i++) begin
      light_d[3*i +: 3] = LAMP_R;
      if (grant_d == 2'(i)) begin
        if (state_d == ST_GREEN) begin
          light_d[3*i +: 3] = LAMP_G;
        end else if (state_d == ST_YELLOW) begin
          light_d[3*i +: 3] = LAMP_Y;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ALL_RED;
      cnt_q      <= '0;
      grant_q    <= 2'd3;
      light_q    <= LIGHT_RST;
      walk_q     <= 1'b0;
      ped_pend_q <= 1'b0;
      ped_last_q <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      light_q    <= light_d;
      walk_q     <= walk_d;
      ped_pend_q <= ped_pend_d;
      ped_last_q <= ped_last_d;
      sync_q     <= sync_d;
    end
  end

  assign light = light_q;
  assign walk  = walk_q;
  assign grant = grant_q;
  assign phase = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Purpose: scoreboard bench for intersection_scheduler against a duration-based reference model.
// Latency: model predicts the post-edge outputs of every clk edge; monitor compares 1 time unit after each edge.
// Backpressure: n/a; outputs are compared every cycle.
module tb_intersection_scheduler;

  localparam int T_GMIN = 4;
  localparam int T_GMAX = 12;
  localparam int T_Y    = 3;
  localparam int T_AR   = 2;
  localparam int T_W    = 6;

  // Phase numbering used by the model (matches the phase output encoding).
  localparam int P_RED = 0;
  localparam int P_GRN = 1;
  localparam int P_YEL = 2;
  localparam int P_WLK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic        ped_bt;
  logic [11:0] light;
  logic        walk;
  logic [1:0]  grant;
  logic [1:0]  phase;

  always #5 clk = ~clk;

  intersection_scheduler #(
    .CNT_W(8), .T_GREEN_MIN(T_GMIN), .T_GREEN_MAX(T_GMAX),
    .T_YELLOW(T_Y), .T_ALLRED(T_AR), .T_WALK(T_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ped_bt(ped_bt),
    .light(light), .walk(walk), .grant(grant), .phase(phase)
  );

  typedef struct packed {
    logic [11:0] light;
    logic        walk;
    logic [1:0]  grant;
    logic [1:0]  phase;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which phase is showing, which approach owns it,
  // how many cycles it has been on display, and the pedestrian memory.
  int m_phase, m_grant, m_shown;
  bit m_pend, m_last;
  bit h0, h1, h2;   // button samples from the last three edges, h0 newest

  task automatic model_reset();
    m_phase = P_RED; m_grant = 3; m_shown = 0;
    m_pend = 0; m_last = 0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic p);
    bit press, entered_walk, others;
    int g;
    // A press becomes pending two edges after the synchroniser sees it rise.
    press = h1 && !h2;
    h2 = h1; h1 = h0; h0 = p;
    entered_walk = 0;
    m_shown++;
    case (m_phase)
      P_RED: begin
        if (m_shown >= T_AR) begin
          if (m_pend && !(m_last && r != 4'd0)) begin
            m_phase = P_WLK; m_shown = 0; m_last = 1; entered_walk = 1;
          end else if (r != 4'd0) begin
            g = -1;
            for (int k = 4; k >= 1; k--) if (r[(m_grant + k) % 4]) g = (m_grant + k) % 4;
            m_grant = g; m_phase = P_GRN; m_shown = 0; m_last = 0;
          end
        end
      end
      P_GRN: begin
        others = 0;
        for (int j = 0; j < 4; j++) if (j != m_grant && r[j]) others = 1;
        if ((m_shown >= T_GMIN && !r[m_grant]) ||
            (m_shown >= T_GMAX && (others || m_pend))) begin
          m_phase = P_YEL; m_shown = 0;
        end
      end
      P_YEL: if (m_shown >= T_Y) begin m_phase = P_RED; m_shown = 0; end
      default: if (m_shown >= T_W) begin m_phase = P_RED; m_shown = 0; end
    endcase
    m_pend = press || (m_pend && !entered_walk);
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      o.light[3*i +: 3] = 3'b001;
      if (i == m_grant && m_phase == P_GRN) o.light[3*i +: 3] = 3'b100;
      if (i == m_grant && m_phase == P_YEL) o.light[3*i +: 3] = 3'b010;
    end
    o.walk  = (m_phase == P_WLK);
    o.grant = 2'(m_grant);
    o.phase = 2'(m_phase);
    return o;
  endfunction

  // Stimulus side of the scoreboard: every edge yields one expected observation.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step(req, ped_bt);
    exp_q.push_back(model_obs());
  end

  // Monitor: pops one expectation per edge and compares away from the edge.
  initial begin
    obs_t e_o, a_o;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t: no expected entry", $time);
      end else begin
        e_o = exp_q.pop_front();
        a_o = {light, walk, grant, phase};
        if (a_o !== e_o) begin
          errors++;
          $display("FAIL cycle_out t=%0t: got light=%b walk=%b grant=%0d phase=%0d, expected light=%b walk=%b grant=%0d phase=%0d",
                   $time, a_o.light, a_o.walk, a_o.grant, a_o.phase,
                   e_o.light, e_o.walk, e_o.grant, e_o.phase);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, got, expv);
    end
  endtask

  task automatic drive(input logic [3:0] r, input int n);
    repeat (n) begin
      @(negedge clk);
      req = r;
      ped_bt = 1'b0;
    end
  endtask

  initial begin
    bit reached;
    rst = 1'b1; req = 4'd0; ped_bt = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Uncontested demand on approach 0, then release.
    drive(4'b0001, 30);
    drive(4'b0000, 20);
    // Full contention rotation.
    drive(4'b1111, 150);
    drive(4'b0000, 30);
    // One-cycle pulse on approach 2 while idle: minimum green.
    drive(4'b0100, 1);
    drive(4'b0000, 20);

    // Pedestrian arbitration with 1 and 3 waiting: press during green of 1, again during walk.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req = 4'b1010;
      ped_bt = (i == 22 || i == 23 || i == 36 || i == 37);
    end

    // Press edge landing on the walk-entry edge must stay pending:
    // presses sampled at P, P+5, P+9 give walks entering at P+3, P+11 and P+19.
    drive(4'b0000, 40);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ped_bt = (i == 0 || i == 5 || i == 9);
    end
    @(posedge clk);
    #1;
    chk("set_wins_third_walk", int'(walk), 1);

    // Reset in the middle of approach-2 green.
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      req = 4'b0100;
      ped_bt = 1'b0;
      reached = (m_phase == P_GRN && m_grant == 2);
    end
    chk("reach_green2", int'(reached), 1);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_light", int'(light), 12'h249);
    chk("async_rst_walk", int'(walk), 0);
    chk("async_rst_grant", int'(grant), 3);
    chk("async_rst_phase", int'(phase), 0);
    @(negedge clk);
    req = 4'b0001;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_allred", int'(light), 12'h249);
    @(posedge clk);
    #1;
    chk("post_rst_green0", int'(light[2:0]), 3'b100);

    // Randomised traffic and button presses.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) req = 4'($urandom);
      ped_bt = ($urandom_range(0, 24) == 0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
